// File: rtl/serial_add_sub_pkg.sv
// serial_add_sub_pkg: FSM encoding, legal WIDTH range and counter-width derivation
package serial_add_sub_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
  function automatic bit width_ok(input int w);
    return w >= WIDTH_MIN && w <= WIDTH_MAX;
  endfunction
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/fa_cell.sv
// fa_cell: combinational gate-level full adder
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ cin;
  assign co = (a & b) | (cin & p);
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: LSB-first bit-serial adder/subtractor with ready/busy/done handshake
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CNT_W = cnt_w(WIDTH);
  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("serial_add_sub: WIDTH out of range 1..64");
  end
  logic [1:0]       state;
  logic [WIDTH-1:0] ra, rb, res, res_next;
  logic [CNT_W-1:0] cnt;
  logic             c, s_bit, c_next, last;
  fa_cell u_fa (.a(ra[0]), .b(rb[0]), .cin(c), .s(s_bit), .co(c_next));
  assign res_next = WIDTH'({s_bit, res} >> 1);
  assign last     = cnt == CNT_W'(WIDTH - 1);
  assign ready    = state == ST_IDLE;
  assign busy     = state == ST_RUN || state == ST_DONE;
  assign done     = state == ST_DONE;
  // FSM, operand/result shifting, carry flop, and result capture on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ra    <= '0;
      rb    <= '0;
      res   <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          ra    <= a;
          rb    <= sub ? ~b : b;
          c     <= sub;
          cnt   <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          res <= res_next;
          c   <= c_next;
          cnt <= last ? cnt : cnt + 1'b1;
          if (last) begin
            state <= ST_DONE;
            sum   <= res_next;
            cout  <= c_next;
            ovf   <= c ^ c_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: table-driven and sequence checks at WIDTH=8, 1 and 13
module tb_serial_add_sub;
  logic clk, rst_n;
  logic st8, sb8, r8, b8, d8, c8, o8;
  logic [7:0] a8, bb8, s8;
  logic st1, sb1, r1, b1, d1, c1, o1;
  logic [0:0] a1, bb1, s1;
  logic st13, sb13, r13, b13, d13, c13, o13;
  logic [12:0] a13, bb13, s13;
  int total = 0;
  int bad = 0;

  serial_add_sub #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .start(st8), .sub(sb8), .a(a8), .b(bb8),
    .ready(r8), .busy(b8), .done(d8), .sum(s8), .cout(c8), .ovf(o8));
  serial_add_sub #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .start(st1), .sub(sb1), .a(a1), .b(bb1),
    .ready(r1), .busy(b1), .done(d1), .sum(s1), .cout(c1), .ovf(o1));
  serial_add_sub #(.WIDTH(13)) u13 (.clk(clk), .rst_n(rst_n), .start(st13), .sub(sb13), .a(a13), .b(bb13),
    .ready(r13), .busy(b13), .done(d13), .sum(s13), .cout(c13), .ovf(o13));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] a, b;
    logic       sub;
    logic [7:0] sum;
    logic       cout, ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
    end
  endtask

  function automatic logic rdy(input int w);
    return w == 1 ? r1 : w == 8 ? r8 : r13;
  endfunction
  function automatic logic bsy(input int w);
    return w == 1 ? b1 : w == 8 ? b8 : b13;
  endfunction
  function automatic logic dn(input int w);
    return w == 1 ? d1 : w == 8 ? d8 : d13;
  endfunction
  function automatic logic [63:0] sumv(input int w);
    return w == 1 ? 64'(s1) : w == 8 ? 64'(s8) : 64'(s13);
  endfunction
  function automatic logic cov(input int w);
    return w == 1 ? c1 : w == 8 ? c8 : c13;
  endfunction
  function automatic logic ovv(input int w);
    return w == 1 ? o1 : w == 8 ? o8 : o13;
  endfunction

  task automatic drive(input int w, input logic st, input logic [63:0] av, input logic [63:0] bv, input logic sv);
    case (w)
      1: begin st1 = st; a1 = av[0:0]; bb1 = bv[0:0]; sb1 = sv; end
      8: begin st8 = st; a8 = av[7:0]; bb8 = bv[7:0]; sb8 = sv; end
      default: begin st13 = st; a13 = av[12:0]; bb13 = bv[12:0]; sb13 = sv; end
    endcase
  endtask

  // one full operation: start, mid-run checks with scrambled inputs, wait for done, check pulse width
  task automatic run_op(input int w, input logic [63:0] av, input logic [63:0] bv, input logic sv,
                        input logic [63:0] prev, output logic [63:0] sm, output logic co,
                        output logic ov, output int lat);
    int k;
    k = 0;
    while (!rdy(w) && k < 100) begin @(negedge clk); k++; end
    drive(w, 1'b1, av, bv, sv);
    @(negedge clk);
    drive(w, 1'b0, ~av, ~bv, ~sv);
    chk("ready_in_run", 64'(rdy(w)), 64'd0);
    chk("busy_in_run", 64'(bsy(w)), 64'd1);
    chk("sum_hold_in_run", sumv(w), prev);
    lat = 0;
    while (!dn(w) && lat < 100) begin @(negedge clk); lat++; end
    sm = sumv(w);
    co = cov(w);
    ov = ovv(w);
    @(negedge clk);
    chk("done_one_cycle", 64'(dn(w)), 64'd0);
    chk("ready_after_done", 64'(rdy(w)), 64'd1);
  endtask

  initial begin
    vec_t v8[8];
    vec_t v1[4];
    logic [63:0] sm, prev;
    logic co, ov;
    int lat, pulses, t_prev, ndone;
    v8[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    v8[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    v8[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    v8[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    v8[4] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    v8[5] = '{8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1};
    v8[6] = '{8'h80, 8'h7F, 1'b1, 8'h01, 1'b1, 1'b1};
    v8[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    v1[0] = '{8'h1, 8'h1, 1'b0, 8'h0, 1'b1, 1'b1};
    v1[1] = '{8'h1, 8'h1, 1'b1, 8'h0, 1'b1, 1'b0};
    v1[2] = '{8'h0, 8'h1, 1'b1, 8'h1, 1'b0, 1'b1};
    v1[3] = '{8'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0};
    rst_n = 1'b0;
    drive(1, 1'b0, 64'd0, 64'd0, 1'b0);
    drive(8, 1'b0, 64'd0, 64'd0, 1'b0);
    drive(13, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(r8), 64'd1);
    chk("reset_busy", 64'(b8), 64'd0);
    chk("reset_done", 64'(d8), 64'd0);
    chk("reset_sum", 64'(s8), 64'd0);
    chk("reset_cout", 64'(c8), 64'd0);
    chk("reset_ovf", 64'(o8), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    prev = 64'd0;
    for (int i = 0; i < 8; i++) begin
      run_op(8, 64'(v8[i].a), 64'(v8[i].b), v8[i].sub, prev, sm, co, ov, lat);
      chk($sformatf("w8_latency_%0d", i), 64'(lat), 64'd8);
      chk($sformatf("w8_sum_%0d", i), sm, 64'(v8[i].sum));
      chk($sformatf("w8_cout_%0d", i), 64'(co), 64'(v8[i].cout));
      chk($sformatf("w8_ovf_%0d", i), 64'(ov), 64'(v8[i].ovf));
      prev = 64'(v8[i].sum);
    end
    // a second start in RUN cycle 3 must be ignored
    drive(8, 1'b1, 64'h10, 64'h20, 1'b0);
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 0) drive(8, 1'b0, 64'h10, 64'h20, 1'b0);
      if (i == 2) drive(8, 1'b1, 64'hAA, 64'h55, 1'b0);
      if (i == 3) drive(8, 1'b0, 64'hAA, 64'h55, 1'b0);
      pulses += int'(d8);
    end
    chk("ignored_start_pulses", 64'(pulses), 64'd1);
    chk("ignored_start_sum", 64'(s8), 64'h30);
    chk("ignored_start_busy", 64'(b8), 64'd0);
    // start held high: one op every WIDTH+2 cycles
    drive(8, 1'b1, 64'h01, 64'h02, 1'b0);
    t_prev = -1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d8) begin
        if (t_prev >= 0) chk("b2b_gap", 64'(i - t_prev), 64'd10);
        t_prev = i;
        ndone++;
      end
    end
    drive(8, 1'b0, 64'h0, 64'h0, 1'b0);
    chk("b2b_count", 64'(ndone), 64'd4);
    chk("b2b_sum", 64'(s8), 64'h03);
    // reset in RUN cycle 4 aborts with no done
    @(negedge clk);
    drive(8, 1'b1, 64'h33, 64'h11, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, 64'h0, 64'h0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 64'(r8), 64'd1);
    chk("abort_busy", 64'(b8), 64'd0);
    chk("abort_done", 64'(d8), 64'd0);
    chk("abort_sum", 64'(s8), 64'd0);
    chk("abort_cout", 64'(c8), 64'd0);
    chk("abort_ovf", 64'(o8), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pulses += int'(d8);
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    run_op(8, 64'h01, 64'h01, 1'b0, 64'd0, sm, co, ov, lat);
    chk("post_abort_sum", sm, 64'h02);
    chk("post_abort_latency", 64'(lat), 64'd8);
    // WIDTH=1
    prev = 64'd0;
    for (int i = 0; i < 4; i++) begin
      run_op(1, 64'(v1[i].a), 64'(v1[i].b), v1[i].sub, prev, sm, co, ov, lat);
      chk($sformatf("w1_latency_%0d", i), 64'(lat), 64'd1);
      chk($sformatf("w1_result_%0d", i), {sm[61:0], co, ov}, {62'(v1[i].sum), v1[i].cout, v1[i].ovf});
      prev = 64'(v1[i].sum);
    end
    // WIDTH=13 random sweep against an independent arithmetic model
    prev = 64'd0;
    for (int i = 0; i < 1000; i++) begin
      logic [12:0] ar, br, bx, es;
      logic [13:0] t;
      logic sr, eo;
      ar = 13'($urandom);
      br = 13'($urandom);
      sr = 1'($urandom);
      bx = sr ? ~br : br;
      t = {1'b0, ar} + {1'b0, bx} + 14'(sr);
      es = t[12:0];
      eo = (ar[12] == bx[12]) && (es[12] != ar[12]);
      run_op(13, 64'(ar), 64'(br), sr, prev, sm, co, ov, lat);
      chk($sformatf("w13_vec_%0d", i), {sm[49:0], co, ov, 12'(lat)}, {37'd0, es, t[13], eo, 12'd13});
      prev = 64'(es);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
